// File: rtl/alu_multicycle.sv
// alu_multicycle: parametrised CR16 ALU behind a valid/ready handshake.
// Single-cycle ops register their result one cycle after accept; MUL, DIVU
// and REMU iterate one bit per cycle for P_WIDTH cycles before writing back.
module alu_multicycle #(
    parameter int P_WIDTH = 16
) (
    input  logic               I_CLK,
    input  logic               I_RESET,
    input  logic               I_VALID,
    output logic               O_READY,
    input  logic [3:0]         I_OPCODE,
    input  logic [P_WIDTH-1:0] I_A,
    input  logic [P_WIDTH-1:0] I_B,
    input  logic               I_CARRY,
    output logic               O_VALID,
    output logic [P_WIDTH-1:0] O_C,
    output logic [4:0]         O_STATUS
);

    localparam int CNT_W = $clog2(P_WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_LSH  = 4'd8;
    localparam logic [3:0] OP_RSH  = 4'd9;
    localparam logic [3:0] OP_ALSH = 4'd10;
    localparam logic [3:0] OP_ARSH = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;
    localparam logic [3:0] OP_REMU = 4'd13;

    localparam logic [P_WIDTH-1:0] SHIFT_LIM = P_WIDTH'(P_WIDTH);
    localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(P_WIDTH - 1);

    typedef enum logic {S_IDLE = 1'b0, S_ITER = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 accept;
    logic                 last_step;
    logic [P_WIDTH+4:0]   single_res;

    // Iterative datapath: a_p0 = multiplicand/divisor, b_p0 = multiplier/quotient,
    // acc_p0 = product accumulator / partial remainder (one spare bit for the divide).
    logic [3:0]           op_p0;
    logic [P_WIDTH-1:0]   a_p0, b_p0, a_nxt, b_nxt;
    logic [P_WIDTH:0]     acc_p0, acc_nxt, rem_sh, diff;
    logic [P_WIDTH-1:0]   iter_c;
    logic [4:0]           iter_st;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    // Returns {status, result} for every opcode that completes in one cycle.
    function automatic logic [P_WIDTH+4:0] single_op(input logic [3:0] op,
                                                     input logic [P_WIDTH-1:0] a,
                                                     input logic [P_WIDTH-1:0] b,
                                                     input logic cin);
        logic [P_WIDTH:0]          usum;
        logic signed [P_WIDTH-1:0] sa, sb;
        logic [P_WIDTH-1:0]        c;
        logic [4:0]                st;
        logic                      cy;
        usum = '0;
        sa   = a;
        sb   = b;
        c    = '0;
        st   = '0;
        cy   = (op == OP_ADDC) ? cin : 1'b0;
        case (op)
            OP_ADD, OP_ADDC: begin
                usum  = {1'b0, b} + {1'b0, a} + {{P_WIDTH{1'b0}}, cy};
                c     = usum[P_WIDTH-1:0];
                st[0] = usum[P_WIDTH];
                st[1] = (b < a);
                st[2] = (a[P_WIDTH-1] == b[P_WIDTH-1]) && (c[P_WIDTH-1] != a[P_WIDTH-1]);
                // Bit P_WIDTH of the sign-extended sum: both sign bits plus the carry into it.
                st[4] = a[P_WIDTH-1] ^ b[P_WIDTH-1] ^ usum[P_WIDTH];
            end
            OP_SUB: begin
                c     = b - a;
                st[0] = (b < a);
                st[1] = (b < a);
                st[2] = (a[P_WIDTH-1] != b[P_WIDTH-1]) && (c[P_WIDTH-1] == a[P_WIDTH-1]);
                st[4] = (sb < sa);
            end
            OP_NOT: c = ~a;
            OP_AND: c = a & b;
            OP_OR:  c = a | b;
            OP_XOR: c = a ^ b;
            OP_LSH, OP_ALSH: begin
                if (b >= SHIFT_LIM) c = '0;
                else                c = a << b;
            end
            OP_RSH: begin
                if (b >= SHIFT_LIM) c = '0;
                else                c = a >> b;
            end
            OP_ARSH: begin
                if (b >= SHIFT_LIM) c = {P_WIDTH{a[P_WIDTH-1]}};
                else                c = sa >>> b;
            end
            default: c = '0;
        endcase
        // Opcodes 14/15 report an all-zero status, ZERO included.
        if (op < 4'd14) st[3] = (c == '0);
        return {st, c};
    endfunction

    // Output decode: ready depends on state only.
    always_comb begin
        O_READY = (state_q == S_IDLE);
    end

    assign accept    = I_VALID & O_READY;
    assign last_step = (state_q == S_ITER) && (cnt_q == LAST_CNT);

    // Next-state: multi-cycle opcodes enter ITER, leave after the final step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && is_multi(I_OPCODE)) state_d = S_ITER;
            S_ITER:  if (last_step) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // One shift-add (MUL) or restoring shift-subtract (DIVU/REMU) step.
    always_comb begin
        a_nxt   = a_p0;
        b_nxt   = b_p0;
        acc_nxt = acc_p0;
        rem_sh  = '0;
        diff    = '0;
        if (op_p0 == OP_MUL) begin
            acc_nxt = acc_p0 + (b_p0[0] ? {1'b0, a_p0} : '0);
            a_nxt   = a_p0 << 1;
            b_nxt   = b_p0 >> 1;
        end else begin
            rem_sh = {acc_p0[P_WIDTH-1:0], b_p0[P_WIDTH-1]};
            diff   = rem_sh - {1'b0, a_p0};
            // A zero divisor never borrows, which yields quotient all-ones and remainder B.
            if (!diff[P_WIDTH]) begin
                acc_nxt = diff;
                b_nxt   = {b_p0[P_WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = rem_sh;
                b_nxt   = {b_p0[P_WIDTH-2:0], 1'b0};
            end
        end
    end

    // Result selection for the iterative ops, taken from the final step's values.
    always_comb begin
        iter_c  = (op_p0 == OP_DIVU) ? b_nxt : acc_nxt[P_WIDTH-1:0];
        iter_st = {1'b0, (iter_c == '0), (op_p0 != OP_MUL) && (a_p0 == '0), 2'b00};
    end

    // Single-cycle result computed straight from the request operands.
    always_comb begin
        single_res = single_op(I_OPCODE, I_A, I_B, I_CARRY);
    end

    // Iteration operands: loaded at accept, stepped every ITER cycle.
    always_ff @(posedge I_CLK) begin
        if (accept) begin
            op_p0  <= I_OPCODE;
            a_p0   <= I_A;
            b_p0   <= I_B;
            acc_p0 <= '0;
        end else if (state_q == S_ITER) begin
            a_p0   <= a_nxt;
            b_p0   <= b_nxt;
            acc_p0 <= acc_nxt;
        end
    end

    // Iteration counter and result/valid registers.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            cnt_q    <= '0;
            O_VALID  <= 1'b0;
            O_C      <= '0;
            O_STATUS <= '0;
        end else begin
            O_VALID <= 1'b0;
            if (accept) begin
                cnt_q <= '0;
                if (!is_multi(I_OPCODE)) begin
                    O_C      <= single_res[P_WIDTH-1:0];
                    O_STATUS <= single_res[P_WIDTH+4:P_WIDTH];
                    O_VALID  <= 1'b1;
                end
            end else if (state_q == S_ITER) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_step) begin
                    cnt_q    <= '0;
                    O_C      <= iter_c;
                    O_STATUS <= iter_st;
                    O_VALID  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed and randomized checks of alu_multicycle (P_WIDTH=16)
// against an integer-arithmetic reference model.
module tb_alu_multicycle;

    localparam int W = 16;

    logic          I_CLK = 1'b0;
    logic          I_RESET = 1'b1;
    logic          I_VALID = 1'b0;
    logic          O_READY;
    logic [3:0]    I_OPCODE = '0;
    logic [W-1:0]  I_A = '0;
    logic [W-1:0]  I_B = '0;
    logic          I_CARRY = 1'b0;
    logic          O_VALID;
    logic [W-1:0]  O_C;
    logic [4:0]    O_STATUS;

    int n_tests = 0;
    int n_fail  = 0;

    alu_multicycle #(.P_WIDTH(W)) dut (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .I_VALID(I_VALID), .O_READY(O_READY),
        .I_OPCODE(I_OPCODE), .I_A(I_A), .I_B(I_B), .I_CARRY(I_CARRY),
        .O_VALID(O_VALID), .O_C(O_C), .O_STATUS(O_STATUS)
    );

    always #5 I_CLK = ~I_CLK;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Reference model: {status, result} from plain integer arithmetic.
    function automatic logic [20:0] ref_model(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic cin);
        int ua, ub, sa, sb, r, ci;
        logic [15:0] c;
        logic [4:0]  st;
        ua = {16'd0, a};
        ub = {16'd0, b};
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        ci = (op == 4'd1 && cin) ? 1 : 0;
        c  = '0;
        st = '0;
        case (op)
            4'd0, 4'd1: begin
                r = ua + ub + ci;
                c = r[15:0];
                st[0] = (r > 65535);
                st[1] = (ub < ua);
                r = sa + sb + ci;
                st[2] = (r > 32767) || (r < -32768);
                st[4] = (r < 0);
            end
            4'd2: begin r = sa * sb; c = r[15:0]; end
            4'd3: begin
                r = ub - ua;
                c = r[15:0];
                st[0] = (ub < ua);
                st[1] = (ub < ua);
                r = sb - sa;
                st[2] = (r > 32767) || (r < -32768);
                st[4] = (sb < sa);
            end
            4'd4: c = ~a;
            4'd5: c = a & b;
            4'd6: c = a | b;
            4'd7: c = a ^ b;
            4'd8, 4'd10: begin if (ub < 16) begin r = ua << ub; c = r[15:0]; end end
            4'd9:  begin if (ub < 16) begin r = ua >> ub; c = r[15:0]; end end
            4'd11: begin
                if (ub >= 16) c = a[15] ? 16'hFFFF : 16'h0000;
                else begin r = sa >>> ub; c = r[15:0]; end
            end
            4'd12: begin
                if (ua == 0) begin c = 16'hFFFF; st[2] = 1'b1; end
                else begin r = ub / ua; c = r[15:0]; end
            end
            4'd13: begin
                if (ua == 0) begin c = b; st[2] = 1'b1; end
                else begin r = ub % ua; c = r[15:0]; end
            end
            default: c = '0;
        endcase
        if (op < 4'd14) st[3] = (c == 16'h0000);
        return {st, c};
    endfunction

    task automatic step();
        @(posedge I_CLK);
        #1;
    endtask

    // Issue one request (READY assumed high), scramble inputs, wait for the result.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, output logic [15:0] c, output logic [4:0] st,
                          output int lat, output int rl);
        I_OPCODE = op; I_A = a; I_B = b; I_CARRY = cin; I_VALID = 1'b1;
        step();
        I_VALID  = 1'b0;
        I_OPCODE = 4'($urandom); I_A = 16'($urandom); I_B = 16'($urandom); I_CARRY = 1'($urandom);
        lat = 1;
        rl  = 0;
        while (O_VALID !== 1'b1 && lat < 40) begin
            if (O_READY === 1'b0) rl++;
            step();
            lat++;
        end
        c  = O_C;
        st = O_STATUS;
    endtask

    task automatic test_reset();
        I_RESET = 1'b1;
        repeat (3) step();
        n_tests++; if (O_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", O_READY); end
        n_tests++; if (O_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", O_VALID); end
        n_tests++; if (O_C !== 16'h0000) begin n_fail++; $display("FAIL reset_c got=%h exp=0000", O_C); end
        n_tests++; if (O_STATUS !== 5'h00) begin n_fail++; $display("FAIL reset_status got=%b exp=00000", O_STATUS); end
        I_RESET = 1'b0;
        step();
    endtask

    task automatic test_add_sub();
        logic [15:0] c; logic [4:0] st; int lat, rl;
        run_op(4'd0, 16'h0001, 16'h7FFF, 1'b0, c, st, lat, rl);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency got=%0d exp=1", lat); end
        n_tests++; if (c !== 16'h8000) begin n_fail++; $display("FAIL add_c got=%h exp=8000", c); end
        n_tests++; if (st !== 5'b00100) begin n_fail++; $display("FAIL add_status got=%b exp=00100", st); end
        run_op(4'd3, 16'h0005, 16'h0003, 1'b0, c, st, lat, rl);
        n_tests++; if (c !== 16'hFFFE) begin n_fail++; $display("FAIL sub_c got=%h exp=fffe", c); end
        n_tests++; if (st !== 5'b10011) begin n_fail++; $display("FAIL sub_status got=%b exp=10011", st); end
        run_op(4'd1, 16'hFFFF, 16'h0000, 1'b1, c, st, lat, rl);
        n_tests++; if (c !== 16'h0000) begin n_fail++; $display("FAIL addc_c got=%h exp=0000", c); end
        n_tests++; if (st !== 5'b01011) begin n_fail++; $display("FAIL addc_status got=%b exp=01011", st); end
    endtask

    task automatic test_mul();
        logic [15:0] c; logic [4:0] st; int lat, rl;
        run_op(4'd2, 16'hFFFD, 16'h0007, 1'b0, c, st, lat, rl);
        n_tests++; if (lat !== 17) begin n_fail++; $display("FAIL mul_latency got=%0d exp=17", lat); end
        n_tests++; if (rl !== 16) begin n_fail++; $display("FAIL mul_ready_low got=%0d exp=16", rl); end
        n_tests++; if (c !== 16'hFFEB) begin n_fail++; $display("FAIL mul_c got=%h exp=ffeb", c); end
        n_tests++; if (st !== 5'b00000) begin n_fail++; $display("FAIL mul_status got=%b exp=00000", st); end
        n_tests++; if (O_READY !== 1'b1) begin n_fail++; $display("FAIL mul_ready_back got=%b exp=1", O_READY); end
        step();
        n_tests++; if (O_VALID !== 1'b0) begin n_fail++; $display("FAIL mul_valid_pulse got=%b exp=0", O_VALID); end
        n_tests++; if (O_C !== 16'hFFEB) begin n_fail++; $display("FAIL mul_hold got=%h exp=ffeb", O_C); end
    endtask

    task automatic test_div();
        logic [15:0] c; logic [4:0] st; int lat, rl;
        run_op(4'd12, 16'd7, 16'd100, 1'b0, c, st, lat, rl);
        n_tests++; if (c !== 16'd14) begin n_fail++; $display("FAIL divu_c got=%0d exp=14", c); end
        n_tests++; if (lat !== 17) begin n_fail++; $display("FAIL divu_latency got=%0d exp=17", lat); end
        run_op(4'd13, 16'd7, 16'd100, 1'b0, c, st, lat, rl);
        n_tests++; if (c !== 16'd2) begin n_fail++; $display("FAIL remu_c got=%0d exp=2", c); end
        n_tests++; if (st !== 5'b00000) begin n_fail++; $display("FAIL remu_status got=%b exp=00000", st); end
        run_op(4'd12, 16'h0000, 16'h1234, 1'b0, c, st, lat, rl);
        n_tests++; if (c !== 16'hFFFF) begin n_fail++; $display("FAIL divu0_c got=%h exp=ffff", c); end
        n_tests++; if (st !== 5'b00100) begin n_fail++; $display("FAIL divu0_status got=%b exp=00100", st); end
        n_tests++; if (lat !== 17) begin n_fail++; $display("FAIL divu0_latency got=%0d exp=17", lat); end
        run_op(4'd13, 16'h0000, 16'h1234, 1'b0, c, st, lat, rl);
        n_tests++; if (c !== 16'h1234) begin n_fail++; $display("FAIL remu0_c got=%h exp=1234", c); end
        n_tests++; if (st !== 5'b00100) begin n_fail++; $display("FAIL remu0_status got=%b exp=00100", st); end
    endtask

    task automatic test_shift();
        logic [15:0] c; logic [4:0] st; int lat, rl;
        run_op(4'd11, 16'h8000, 16'd20, 1'b0, c, st, lat, rl);
        n_tests++; if (c !== 16'hFFFF) begin n_fail++; $display("FAIL arsh_big_c got=%h exp=ffff", c); end
        n_tests++; if (st !== 5'b00000) begin n_fail++; $display("FAIL arsh_big_status got=%b exp=00000", st); end
        run_op(4'd9, 16'h8000, 16'd20, 1'b0, c, st, lat, rl);
        n_tests++; if (c !== 16'h0000) begin n_fail++; $display("FAIL rsh_big_c got=%h exp=0000", c); end
        n_tests++; if (st !== 5'b01000) begin n_fail++; $display("FAIL rsh_big_status got=%b exp=01000", st); end
        run_op(4'd8, 16'h0001, 16'd16, 1'b0, c, st, lat, rl);
        n_tests++; if (c !== 16'h0000) begin n_fail++; $display("FAIL lsh_16_c got=%h exp=0000", c); end
    endtask

    task automatic test_back_to_back();
        int singles[13] = '{0, 1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 14, 15};
        logic [3:0] op; logic [15:0] a, b; logic cin; logic [20:0] exp;
        for (int i = 0; i < 4; i++) begin
            op  = 4'(singles[$urandom_range(0, 12)]);
            a   = 16'($urandom);
            b   = (op >= 4'd8) ? 16'($urandom_range(0, 18)) : 16'($urandom);
            cin = 1'($urandom);
            exp = ref_model(op, a, b, cin);
            I_OPCODE = op; I_A = a; I_B = b; I_CARRY = cin; I_VALID = 1'b1;
            step();
            n_tests++; if (O_VALID !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, O_VALID); end
            n_tests++; if ({O_STATUS, O_C} !== exp) begin n_fail++; $display("FAIL b2b_result[%0d] op=%0d got=%h exp=%h", i, op, {O_STATUS, O_C}, exp); end
        end
        I_VALID = 1'b0;
        step();
        n_tests++; if (O_VALID !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_valid got=%b exp=0", O_VALID); end
    endtask

    task automatic test_hold_while_busy();
        int cyc;
        I_OPCODE = 4'd2; I_A = 16'd3; I_B = 16'd5; I_VALID = 1'b1;
        step();
        I_OPCODE = 4'd0; I_A = 16'h0010; I_B = 16'h0020;
        cyc = 1;
        while (O_VALID !== 1'b1 && cyc < 40) begin step(); cyc++; end
        n_tests++; if (cyc !== 17) begin n_fail++; $display("FAIL hold_mul_latency got=%0d exp=17", cyc); end
        n_tests++; if (O_C !== 16'd15) begin n_fail++; $display("FAIL hold_mul_c got=%h exp=000f", O_C); end
        step();
        I_VALID = 1'b0;
        n_tests++; if (O_VALID !== 1'b1 || O_C !== 16'h0030) begin n_fail++; $display("FAIL hold_add got=%b/%h exp=1/0030", O_VALID, O_C); end
        step();
        n_tests++; if (O_VALID !== 1'b0) begin n_fail++; $display("FAIL hold_single_accept got=%b exp=0", O_VALID); end
    endtask

    task automatic test_random();
        logic [3:0] op; logic [15:0] a, b, c; logic cin; logic [4:0] st; logic [20:0] exp;
        int lat, rl, exp_lat;
        for (int i = 0; i < 200; i++) begin
            op  = 4'($urandom);
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            case ($urandom_range(0, 3))
                0: b = 16'($urandom_range(0, 20));
                1: a = 16'($urandom_range(0, 3));
                default: ;
            endcase
            exp     = ref_model(op, a, b, cin);
            exp_lat = (op == 4'd2 || op == 4'd12 || op == 4'd13) ? 17 : 1;
            run_op(op, a, b, cin, c, st, lat, rl);
            n_tests++; if ({st, c} !== exp) begin n_fail++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h cin=%b got=%h exp=%h", i, op, a, b, cin, {st, c}, exp); end
            n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand_latency[%0d] op=%0d got=%0d exp=%0d", i, op, lat, exp_lat); end
        end
    endtask

    task automatic test_reset_midop();
        logic [15:0] c; logic [4:0] st; int lat, rl, seen;
        run_op(4'd0, 16'd1, 16'd1, 1'b0, c, st, lat, rl);
        n_tests++; if (c !== 16'd2) begin n_fail++; $display("FAIL pre_reset_add got=%h exp=0002", c); end
        I_OPCODE = 4'd12; I_A = 16'd7; I_B = 16'd100; I_VALID = 1'b1;
        step();
        I_VALID = 1'b0;
        repeat (5) step();
        I_RESET = 1'b1;
        step();
        I_RESET = 1'b0;
        n_tests++; if (O_READY !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", O_READY); end
        n_tests++; if (O_VALID !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", O_VALID); end
        n_tests++; if (O_C !== 16'h0000 || O_STATUS !== 5'h00) begin n_fail++; $display("FAIL midrst_outputs got=%h/%b exp=0000/00000", O_C, O_STATUS); end
        seen = 0;
        repeat (25) begin step(); if (O_VALID === 1'b1) seen++; end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_result got=%0d exp=0", seen); end
        run_op(4'd0, 16'h1111, 16'h2222, 1'b0, c, st, lat, rl);
        n_tests++; if (c !== 16'h3333 || lat !== 1) begin n_fail++; $display("FAIL midrst_next_add got=%h/%0d exp=3333/1", c, lat); end
        // Reset coinciding with a request drops it.
        I_OPCODE = 4'd0; I_A = 16'd1; I_B = 16'd1; I_VALID = 1'b1; I_RESET = 1'b1;
        step();
        I_RESET = 1'b0; I_VALID = 1'b0;
        n_tests++; if (O_VALID !== 1'b0 || O_C !== 16'h0000) begin n_fail++; $display("FAIL rst_prio got=%b/%h exp=0/0000", O_VALID, O_C); end
        step();
        n_tests++; if (O_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_prio_dropped got=%b exp=0", O_VALID); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_shift();
        test_back_to_back();
        test_hold_while_busy();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
